// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: hazard-detection inputs from the pipeline and the
// per-stage stall/flush controls returned to it. The pipeline side is the master.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic [4:0]       i_rs1_addr_d;
  logic [4:0]       i_rs2_addr_d;
  logic [1:0]       i_rs_used_d;
  logic [4:0]       i_rd_addr_e;
  logic             i_reg_write_e;
  logic [1:0]       i_result_src_e;
  logic             i_pc_src_e;
  logic             i_mem_req_m;
  logic             i_mem_ack;
  logic             o_stall_f;
  logic             o_stall_d;
  logic             o_stall_e;
  logic             o_stall_m;
  logic             o_flush_d;
  logic             o_flush_e;
  logic             o_bubble_w;
  logic             o_mem_err;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_rs1_addr_d, i_rs2_addr_d, i_rs_used_d, i_rd_addr_e, i_reg_write_e,
           i_result_src_e, i_pc_src_e, i_mem_req_m, i_mem_ack,
    input  o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_flush_d, o_flush_e,
           o_bubble_w, o_mem_err, o_state, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_rs1_addr_d, i_rs2_addr_d, i_rs_used_d, i_rd_addr_e, i_reg_write_e,
           i_result_src_e, i_pc_src_e, i_mem_req_m, i_mem_ack,
    output o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_flush_d, o_flush_e,
           o_bubble_w, o_mem_err, o_state, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: post-reset purge, load-use,
// taken-branch and multi-cycle memory waits. Define HAZARD_PERF_CNT_EN for perf counters.
module hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

  localparam int                TMO_W    = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT) + 1;
  localparam bit                TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [TMO_W-1:0]  TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       init_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;

  logic rd_hit_s;
  logic load_use_s;
  logic mem_stall_s;
  logic tmo_hit_s;
  logic stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic flush_d_s, flush_e_s, bubble_w_s, mem_err_s;

  assign rd_hit_s    = (hz.i_rd_addr_e != 5'd0) &&
                       ((hz.i_rs_used_d[0] && (hz.i_rs1_addr_d == hz.i_rd_addr_e)) ||
                        (hz.i_rs_used_d[1] && (hz.i_rs2_addr_d == hz.i_rd_addr_e)));
  assign load_use_s  = (hz.i_result_src_e == 2'b01) && hz.i_reg_write_e && rd_hit_s;
  assign mem_stall_s = hz.i_mem_req_m && !hz.i_mem_ack;
  assign tmo_hit_s   = TMO_EN && (tmo_cnt_r >= TMO_LAST);

  // Next-state and stage-control decode; reset forces the purge pattern immediately.
  always_comb begin
    state_nxt_s = state_r;
    stall_f_s   = 1'b0;
    stall_d_s   = 1'b0;
    stall_e_s   = 1'b0;
    stall_m_s   = 1'b0;
    flush_d_s   = 1'b0;
    flush_e_s   = 1'b0;
    bubble_w_s  = 1'b0;
    mem_err_s   = 1'b0;
    if (i_rst) begin
      stall_f_s   = 1'b1;
      flush_d_s   = 1'b1;
      flush_e_s   = 1'b1;
      bubble_w_s  = 1'b1;
      state_nxt_s = ST_INIT;
    end else begin
      case (state_r)
        ST_INIT: begin
          stall_f_s  = 1'b1;
          flush_d_s  = 1'b1;
          flush_e_s  = 1'b1;
          bubble_w_s = 1'b1;
          if (init_cnt_r >= INIT_LAST) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_INIT;
          end
        end
        ST_RUN: begin
          if (mem_stall_s) begin
            stall_f_s   = 1'b1;
            stall_d_s   = 1'b1;
            stall_e_s   = 1'b1;
            stall_m_s   = 1'b1;
            bubble_w_s  = 1'b1;
            state_nxt_s = ST_MEM_WAIT;
          end else if (hz.i_pc_src_e) begin
            // A redirect squashes the wrong-path consumer, so its load-use stall is dropped.
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
          end else if (load_use_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (hz.i_mem_ack) begin
            state_nxt_s = ST_RUN;
          end else begin
            stall_f_s  = 1'b1;
            stall_d_s  = 1'b1;
            stall_e_s  = 1'b1;
            stall_m_s  = 1'b1;
            bubble_w_s = 1'b1;
            if (tmo_hit_s) begin
              state_nxt_s = ST_ERR;
            end else begin
              state_nxt_s = ST_MEM_WAIT;
            end
          end
        end
        ST_ERR: begin
          mem_err_s   = 1'b1;
          bubble_w_s  = 1'b1;
          state_nxt_s = ST_RUN;
        end
        default: begin
          stall_f_s   = 1'b1;
          flush_d_s   = 1'b1;
          flush_e_s   = 1'b1;
          bubble_w_s  = 1'b1;
          state_nxt_s = ST_INIT;
        end
      endcase
    end
  end

  // State register plus purge and access-timeout counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_INIT;
      init_cnt_r <= 4'd0;
      tmo_cnt_r  <= {TMO_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_INIT) begin
        init_cnt_r <= init_cnt_r + 4'd1;
      end else begin
        init_cnt_r <= 4'd0;
      end
      // The issuing RUN cycle counts as the first wait cycle of the access.
      case (state_r)
        ST_RUN:      tmo_cnt_r <= mem_stall_s ? TMO_ONE : {TMO_W{1'b0}};
        ST_MEM_WAIT: tmo_cnt_r <= TMO_EN ? (tmo_cnt_r + TMO_ONE) : tmo_cnt_r;
        default:     tmo_cnt_r <= {TMO_W{1'b0}};
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Perf counters; the purge window is excluded and both wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if ((state_r != ST_INIT) && stall_f_s) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if ((state_r != ST_INIT) && flush_d_s) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign hz.o_stall_cnt = stall_cnt_r;
  assign hz.o_flush_cnt = flush_cnt_r;
`else
  assign hz.o_stall_cnt = {CNT_W{1'b0}};
  assign hz.o_flush_cnt = {CNT_W{1'b0}};
`endif

  assign hz.o_stall_f  = stall_f_s;
  assign hz.o_stall_d  = stall_d_s;
  assign hz.o_stall_e  = stall_e_s;
  assign hz.o_stall_m  = stall_m_s;
  assign hz.o_flush_d  = flush_d_s;
  assign hz.o_flush_e  = flush_e_s;
  assign hz.o_bubble_w = bubble_w_s;
  assign hz.o_mem_err  = mem_err_s;
  assign hz.o_state    = state_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (INIT_CYCLES=4, MEM_TIMEOUT=16).
// Control word compared as {state, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w, mem_err}.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [9:0] C_INIT = {2'd0, 8'b1000_1110};
  localparam logic [9:0] C_IDLE = {2'd1, 8'b0000_0000};
  localparam logic [9:0] C_LU   = {2'd1, 8'b1100_0100};
  localparam logic [9:0] C_BR   = {2'd1, 8'b0000_1100};
  localparam logic [9:0] C_MREQ = {2'd1, 8'b1111_0010};
  localparam logic [9:0] C_MWT  = {2'd2, 8'b1111_0010};
  localparam logic [9:0] C_MACK = {2'd2, 8'b0000_0000};
  localparam logic [9:0] C_ERR  = {2'd3, 8'b0000_0011};

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] EXP_STALLS  = 32'd5;
  localparam logic [31:0] EXP_FLUSHES = 32'd2;
`else
  localparam logic [31:0] EXP_STALLS  = 32'd0;
  localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) hz ();

  hazard_ctrl #(.INIT_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .hz    (hz)
  );

  function automatic logic [9:0] ctl();
    return {hz.o_state, hz.o_stall_f, hz.o_stall_d, hz.o_stall_e, hz.o_stall_m,
            hz.o_flush_d, hz.o_flush_e, hz.o_bubble_w, hz.o_mem_err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.i_rs1_addr_d   = 5'd0;
    hz.i_rs2_addr_d   = 5'd0;
    hz.i_rs_used_d    = 2'b00;
    hz.i_rd_addr_e    = 5'd0;
    hz.i_reg_write_e  = 1'b0;
    hz.i_result_src_e = 2'b00;
    hz.i_pc_src_e     = 1'b0;
    hz.i_mem_req_m    = 1'b0;
    hz.i_mem_ack      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cyc(); cyc(); cyc();
    n_cmp++;
    if (ctl() !== C_INIT) begin n_fail++; $display("FAIL rst_hold: got %b want %b", ctl(), C_INIT); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (ctl() !== C_INIT) begin n_fail++; $display("FAIL init_%0d: got %b want %b", i, ctl(), C_INIT); end
      cyc();
    end
    #1;
    n_cmp++;
    if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL init_done: got %b want %b", ctl(), C_IDLE); end
    n_cmp++;
    if ((hz.o_stall_cnt !== 32'd0) || (hz.o_flush_cnt !== 32'd0)) begin
      n_fail++; $display("FAIL init_cnt: got %0d/%0d want 0/0", hz.o_stall_cnt, hz.o_flush_cnt);
    end
  endtask

  // Each vector: {src, rw, rd, rs1, rs2, used, pc_src, expected}; an idle cycle follows.
  typedef struct packed {
    logic [1:0] src;
    logic       rw;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] used;
    logic       pc;
    logic [9:0] exp;
  } vec_t;

  task automatic test_load_use_branch();
    vec_t v [9];
    v[0] = '{2'b01, 1'b1, 5'd5, 5'd5, 5'd7, 2'b11, 1'b0, C_LU};   // lw x5; add x6,x5,x7
    v[1] = '{2'b01, 1'b1, 5'd5, 5'd6, 5'd5, 2'b10, 1'b0, C_LU};   // rs2-only hit
    v[2] = '{2'b01, 1'b1, 5'd5, 5'd6, 5'd5, 2'b01, 1'b0, C_IDLE}; // rs2 matches but unused
    v[3] = '{2'b01, 1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0, C_IDLE}; // rd=x0
    v[4] = '{2'b00, 1'b1, 5'd5, 5'd5, 5'd7, 2'b11, 1'b0, C_IDLE}; // ALU producer
    v[5] = '{2'b01, 1'b0, 5'd5, 5'd5, 5'd7, 2'b11, 1'b0, C_IDLE}; // no register write
    v[6] = '{2'b10, 1'b1, 5'd5, 5'd5, 5'd7, 2'b11, 1'b0, C_IDLE}; // non-load source
    v[7] = '{2'b01, 1'b1, 5'd5, 5'd5, 5'd7, 2'b11, 1'b1, C_BR};   // coincident: flush wins
    v[8] = '{2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, C_BR};   // plain taken branch
    for (int i = 0; i < 9; i++) begin
      hz.i_result_src_e = v[i].src;
      hz.i_reg_write_e  = v[i].rw;
      hz.i_rd_addr_e    = v[i].rd;
      hz.i_rs1_addr_d   = v[i].rs1;
      hz.i_rs2_addr_d   = v[i].rs2;
      hz.i_rs_used_d    = v[i].used;
      hz.i_pc_src_e     = v[i].pc;
      #1;
      n_cmp++;
      if (ctl() !== v[i].exp) begin n_fail++; $display("FAIL hz_vec_%0d: got %b want %b", i, ctl(), v[i].exp); end
      cyc();
      idle_inputs();
      #1;
      n_cmp++;
      if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL hz_after_%0d: got %b want %b", i, ctl(), C_IDLE); end
      cyc();
    end
  endtask

  task automatic test_mem_wait();
    hz.i_mem_req_m = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== C_MREQ) begin n_fail++; $display("FAIL mem_req: got %b want %b", ctl(), C_MREQ); end
    cyc();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (ctl() !== C_MWT) begin n_fail++; $display("FAIL mem_wait_%0d: got %b want %b", i, ctl(), C_MWT); end
      cyc();
    end
    hz.i_mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== C_MACK) begin n_fail++; $display("FAIL mem_ack: got %b want %b", ctl(), C_MACK); end
    cyc();
    idle_inputs();
    #1;
    n_cmp++;
    if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL mem_back_run: got %b want %b", ctl(), C_IDLE); end
    n_cmp++;
    if ((hz.o_stall_cnt !== EXP_STALLS) || (hz.o_flush_cnt !== EXP_FLUSHES)) begin
      n_fail++; $display("FAIL perf_cnt: got %0d/%0d want %0d/%0d",
                         hz.o_stall_cnt, hz.o_flush_cnt, EXP_STALLS, EXP_FLUSHES);
    end
    hz.i_mem_req_m = 1'b1;
    hz.i_mem_ack   = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL mem_zero_wait: got %b want %b", ctl(), C_IDLE); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_pending_branch();
    hz.i_mem_req_m = 1'b1;
    hz.i_pc_src_e  = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== C_MREQ) begin n_fail++; $display("FAIL mem_over_br: got %b want %b", ctl(), C_MREQ); end
    cyc();
    hz.i_mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== C_MACK) begin n_fail++; $display("FAIL br_held_ack: got %b want %b", ctl(), C_MACK); end
    cyc();
    hz.i_mem_req_m = 1'b0;
    hz.i_mem_ack   = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== C_BR) begin n_fail++; $display("FAIL br_after_wait: got %b want %b", ctl(), C_BR); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_timeout();
    int n_stall;
    n_stall = 0;
    hz.i_mem_req_m = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (hz.o_state == 2'd3) break;
      if (hz.o_stall_f === 1'b1) n_stall++;
      cyc();
    end
    n_cmp++;
    if (n_stall != 16) begin n_fail++; $display("FAIL tmo_stalls: got %0d want 16", n_stall); end
    n_cmp++;
    if (ctl() !== C_ERR) begin n_fail++; $display("FAIL tmo_err: got %b want %b", ctl(), C_ERR); end
    cyc();
    hz.i_mem_req_m = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL tmo_recover: got %b want %b", ctl(), C_IDLE); end
    cyc();
    // Ack arriving in the last allowed wait cycle retires the access without error.
    hz.i_mem_req_m = 1'b1;
    cyc();
    for (int i = 0; i < 14; i++) cyc();
    hz.i_mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== C_MACK) begin n_fail++; $display("FAIL tmo_edge_ack: got %b want %b", ctl(), C_MACK); end
    cyc();
    idle_inputs();
    #1;
    n_cmp++;
    if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL tmo_edge_run: got %b want %b", ctl(), C_IDLE); end
    cyc();
  endtask

  task automatic test_reset_mid();
    hz.i_mem_req_m = 1'b1;
    cyc();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== {2'd2, C_INIT[7:0]}) begin
      n_fail++; $display("FAIL rst_mid_comb: got %b want %b", ctl(), {2'd2, C_INIT[7:0]});
    end
    cyc();
    n_cmp++;
    if (ctl() !== C_INIT) begin n_fail++; $display("FAIL rst_mid: got %b want %b", ctl(), C_INIT); end
    n_cmp++;
    if ((hz.o_stall_cnt !== 32'd0) || (hz.o_flush_cnt !== 32'd0)) begin
      n_fail++; $display("FAIL rst_cnt_clear: got %0d/%0d want 0/0", hz.o_stall_cnt, hz.o_flush_cnt);
    end
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) cyc();
    #1;
    n_cmp++;
    if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL rst_mid_run: got %b want %b", ctl(), C_IDLE); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use_branch();
    test_mem_wait();
    test_pending_branch();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
